// File: rtl/des_subkey_store.sv
// Subkey buffer between the DES key schedule and the round engine. It loads K1..K16 once,
// then replays them forward or reversed on a valid/ready stream. Option: DES_SUBKEY_PARITY_EN.
module des_subkey_store #(
  parameter int NROUNDS = 16,
  parameter int KW      = 48
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          key_start_i,
  input  logic          kn_valid_i,
  input  logic [1:KW]   kn_i,
  input  logic          kn_done_i,
  input  logic          rd_start_i,
  input  logic          rd_decrypt_i,
  output logic          k_valid_o,
  input  logic          k_ready_i,
  output logic [1:KW]   k_out_o,
  output logic [3:0]    k_round_o,
  output logic          k_last_o,
  output logic          loaded_o,
  output logic          load_err_o,
  output logic          par_err_o
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    LOADED  = 2'd2,
    STREAM  = 2'd3
  } state_e;

  state_e       state_q;
  logic [4:0]   wr_cnt_q;
  logic [3:0]   rd_idx_q;
  logic         dir_q;
  logic         k_valid_q;
  logic [1:KW]  k_out_q;
  logic [3:0]   k_round_q;
  logic         k_last_q;
  logic         loaded_q;
  logic         load_err_q;
  logic [1:KW]  slot_q [NROUNDS];

  logic [4:0]   wr_cnt_inc_d;
  logic         wr_en_d;
  logic         wr_full_d;
  logic         hs_d;
  logic         rd_go_d;
  logic [3:0]   start_idx_d;
  logic [3:0]   nxt_idx_d;

  assign wr_cnt_inc_d = wr_cnt_q + 5'd1;
  assign wr_en_d      = (state_q == LOADING) && kn_valid_i && !key_start_i && (wr_cnt_q < 5'd16);
  assign wr_full_d    = wr_en_d && (wr_cnt_inc_d == 5'd16);
  assign hs_d         = (state_q == STREAM) && k_valid_q && k_ready_i;
  assign rd_go_d      = (state_q == LOADED) && rd_start_i && !key_start_i;
  assign start_idx_d  = rd_decrypt_i ? 4'd15 : 4'd0;
  assign nxt_idx_d    = dir_q ? (rd_idx_q - 4'd1) : (rd_idx_q + 4'd1);

  // Subkey storage is intentionally not reset; only a completed load makes it visible.
  always_ff @(posedge clk) begin
    if (wr_en_d) begin
      slot_q[wr_cnt_q[3:0]] <= kn_i;
    end
  end

  // Control FSM and registered stream outputs; key_start overrides everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      wr_cnt_q   <= 5'd0;
      rd_idx_q   <= 4'd0;
      dir_q      <= 1'b0;
      k_valid_q  <= 1'b0;
      k_out_q    <= '0;
      k_round_q  <= 4'd0;
      k_last_q   <= 1'b0;
      loaded_q   <= 1'b0;
      load_err_q <= 1'b0;
    end else if (key_start_i) begin
      state_q    <= LOADING;
      wr_cnt_q   <= 5'd0;
      loaded_q   <= 1'b0;
      load_err_q <= 1'b0;
      k_valid_q  <= 1'b0;
      k_last_q   <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          state_q <= EMPTY;
        end
        LOADING: begin
          if (wr_en_d) begin
            wr_cnt_q <= wr_cnt_inc_d;
          end
          if (wr_full_d) begin
            state_q  <= LOADED;
            loaded_q <= 1'b1;
          end else if (kn_done_i) begin
            state_q    <= EMPTY;
            load_err_q <= 1'b1;
          end
        end
        LOADED: begin
          if (rd_go_d) begin
            state_q   <= STREAM;
            dir_q     <= rd_decrypt_i;
            rd_idx_q  <= start_idx_d;
            k_valid_q <= 1'b1;
            k_out_q   <= slot_q[start_idx_d];
            k_round_q <= 4'd0;
            k_last_q  <= 1'b0;
          end
        end
        STREAM: begin
          if (hs_d) begin
            if (k_last_q) begin
              state_q   <= LOADED;
              k_valid_q <= 1'b0;
              k_last_q  <= 1'b0;
            end else begin
              rd_idx_q  <= nxt_idx_d;
              k_out_q   <= slot_q[nxt_idx_d];
              k_round_q <= k_round_q + 4'd1;
              k_last_q  <= (k_round_q == 4'd14);
            end
          end
        end
        default: begin
          state_q <= EMPTY;
        end
      endcase
    end
  end

  assign k_valid_o  = k_valid_q;
  assign k_out_o    = k_out_q;
  assign k_round_o  = k_round_q;
  assign k_last_o   = k_last_q;
  assign loaded_o   = loaded_q;
  assign load_err_o = load_err_q;

`ifdef DES_SUBKEY_PARITY_EN
  function automatic logic par_even(input logic [1:KW] v);
    return ^v;
  endfunction

  logic slot_par_q [NROUNDS];
  logic k_par_q;
  logic par_err_q;

  // Parity travels with each slot and with the presented subkey.
  always_ff @(posedge clk) begin
    if (wr_en_d) begin
      slot_par_q[wr_cnt_q[3:0]] <= par_even(kn_i);
    end
    if (rd_go_d) begin
      k_par_q <= slot_par_q[start_idx_d];
    end else if (hs_d && !k_last_q && !key_start_i) begin
      k_par_q <= slot_par_q[nxt_idx_d];
    end
  end

  // Sticky until reset; the stream keeps running after a parity fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else if (hs_d && (par_even(k_out_q) != k_par_q)) begin
      par_err_q <= 1'b1;
    end
  end

  assign par_err_o = par_err_q;
`else
  assign par_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_des_subkey_store.sv
// Randomized self-checking bench for des_subkey_store against an array-based model
// of the stored schedule and its expected replay order.
module tb_des_subkey_store;

  logic        clk;
  logic        rst_n;
  logic        key_start;
  logic        kn_valid;
  logic [47:0] kn;
  logic        kn_done;
  logic        rd_start;
  logic        rd_decrypt;
  logic        k_valid;
  logic        k_ready;
  logic [47:0] k_out;
  logic [3:0]  k_round;
  logic        k_last;
  logic        loaded;
  logic        load_err;
  logic        par_err;

  int tests_run;
  int tests_failed;
  logic [47:0] mem [16];

  des_subkey_store dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_start_i  (key_start),
    .kn_valid_i   (kn_valid),
    .kn_i         (kn),
    .kn_done_i    (kn_done),
    .rd_start_i   (rd_start),
    .rd_decrypt_i (rd_decrypt),
    .k_valid_o    (k_valid),
    .k_ready_i    (k_ready),
    .k_out_o      (k_out),
    .k_round_o    (k_round),
    .k_last_o     (k_last),
    .loaded_o     (loaded),
    .load_err_o   (load_err),
    .par_err_o    (par_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] rand48();
    logic [31:0] a;
    logic [31:0] b;
    a = $urandom;
    b = $urandom;
    return {a[15:0], b};
  endfunction

  // pattern 0: one-hot keys; done_last raises kn_done with the 16th write
  task automatic load_keys(input int pattern, input bit done_last);
    logic [47:0] key;
    key_start = 1'b1;
    step();
    key_start = 1'b0;
    check("load_clr_loaded", {63'd0, loaded}, 64'd0);
    check("load_clr_err", {63'd0, load_err}, 64'd0);
    for (int i = 0; i < 16; i++) begin
      if (($urandom % 3) == 0) begin
        kn_valid = 1'b0;
        kn = rand48();
        step();
      end
      key = (pattern == 0) ? (48'h1 << i) : rand48();
      mem[i] = key;
      kn_valid = 1'b1;
      kn = key;
      kn_done = done_last && (i == 15);
      step();
      if (i == 14) check("loaded_early", {63'd0, loaded}, 64'd0);
    end
    kn_valid = 1'b0;
    kn_done = 1'b0;
    check("loaded_set", {63'd0, loaded}, 64'd1);
    check("load_no_err", {63'd0, load_err}, 64'd0);
  endtask

  // mode 0: ready always high, 1: random ready, 2: ready 1,0,0,1,...
  task automatic replay(input bit dir, input int mode, input int abort_beat);
    int beat;
    int cyc;
    bit rdy;
    logic [47:0] exp;
    rd_start = 1'b1;
    rd_decrypt = dir;
    step();
    rd_start = 1'b0;
    beat = 0;
    cyc = 0;
    while (beat < 16 && cyc < 200) begin
      if (beat == abort_beat) begin
        key_start = 1'b1;
        k_ready = 1'($urandom);
        step();
        key_start = 1'b0;
        check("abort_valid", {63'd0, k_valid}, 64'd0);
        check("abort_loaded", {63'd0, loaded}, 64'd0);
        return;
      end
      exp = dir ? mem[15 - beat] : mem[beat];
      check("k_valid", {63'd0, k_valid}, 64'd1);
      check("k_out", {16'd0, k_out}, {16'd0, exp});
      check("k_round", {60'd0, k_round}, 64'(beat));
      check("k_last", {63'd0, k_last}, {63'd0, (beat == 15)});
      check("loaded_stream", {63'd0, loaded}, 64'd1);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom);
        default: rdy = ((cyc % 3) == 0);
      endcase
      k_ready = rdy;
      kn_valid = 1'($urandom);
      kn = rand48();
      rd_start = 1'($urandom);
      rd_decrypt = 1'($urandom);
      step();
      rd_start = 1'b0;
      cyc++;
      if (rdy) beat++;
    end
    kn_valid = 1'b0;
    check("beats", 64'(beat), 64'd16);
    if (mode == 0) check("cycles", 64'(cyc), 64'd16);
    check("end_valid", {63'd0, k_valid}, 64'd0);
    check("end_loaded", {63'd0, loaded}, 64'd1);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    key_start = 1'b0;
    kn_valid = 1'b0;
    kn = 48'd0;
    kn_done = 1'b0;
    rd_start = 1'b0;
    rd_decrypt = 1'b0;
    k_ready = 1'b0;
    #12;
    check("rst_k_valid", {63'd0, k_valid}, 64'd0);
    check("rst_k_out", {16'd0, k_out}, 64'd0);
    check("rst_k_round", {60'd0, k_round}, 64'd0);
    check("rst_k_last", {63'd0, k_last}, 64'd0);
    check("rst_loaded", {63'd0, loaded}, 64'd0);
    check("rst_load_err", {63'd0, load_err}, 64'd0);
    check("rst_par_err", {63'd0, par_err}, 64'd0);
    rst_n = 1'b1;
    step();

    // rd_start while empty is ignored
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    check("empty_rd_valid", {63'd0, k_valid}, 64'd0);

    load_keys(0, 1'b0);
    replay(1'b0, 0, -1);
    replay(1'b1, 0, -1);
    replay(1'b0, 2, -1);

    // writes and kn_done while loaded change nothing
    for (int i = 0; i < 3; i++) begin
      kn_valid = 1'b1;
      kn = rand48();
      kn_done = (i == 1);
      step();
    end
    kn_valid = 1'b0;
    kn_done = 1'b0;
    check("loaded_done_err", {63'd0, load_err}, 64'd0);
    replay(1'b0, 1, -1);

    load_keys(1, 1'b1);
    replay(1'b1, 1, -1);
    replay(1'b0, 0, 5);

    load_keys(1, 1'b0);
    replay(1'b0, 1, -1);
    replay(1'b1, 2, -1);

    // short schedule: 10 writes then kn_done
    key_start = 1'b1;
    step();
    key_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      kn_valid = 1'b1;
      kn = rand48();
      step();
    end
    kn_valid = 1'b0;
    kn_done = 1'b1;
    step();
    kn_done = 1'b0;
    check("short_err", {63'd0, load_err}, 64'd1);
    check("short_loaded", {63'd0, loaded}, 64'd0);
    rd_start = 1'b1;
    k_ready = 1'b1;
    step();
    rd_start = 1'b0;
    check("short_rd_valid", {63'd0, k_valid}, 64'd0);
    step();
    check("short_err_sticky", {63'd0, load_err}, 64'd1);

    // asynchronous reset in the middle of a stream
    load_keys(1, 1'b0);
    rd_start = 1'b1;
    rd_decrypt = 1'b0;
    step();
    rd_start = 1'b0;
    k_ready = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("arst_valid", {63'd0, k_valid}, 64'd0);
    check("arst_loaded", {63'd0, loaded}, 64'd0);
    check("arst_round", {60'd0, k_round}, 64'd0);
    #2;
    rst_n = 1'b1;
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    check("arst_rd_valid", {63'd0, k_valid}, 64'd0);

`ifdef DES_SUBKEY_PARITY_EN
    load_keys(1, 1'b0);
    dut.slot_q[3][1] = ~dut.slot_q[3][1];
    mem[3][47] = ~mem[3][47];
    rd_start = 1'b1;
    rd_decrypt = 1'b0;
    step();
    rd_start = 1'b0;
    k_ready = 1'b1;
    for (int b = 0; b < 16; b++) begin
      check("par_k_out", {16'd0, k_out}, {16'd0, mem[b]});
      check("par_err", {63'd0, par_err}, {63'd0, (b >= 4)});
      step();
    end
    check("par_err_sticky", {63'd0, par_err}, 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/des_subkey_store.md
# des_subkey_store

Subkey buffer between the DES key-schedule generator and the round engine. It captures the sixteen 48-bit round subkeys K1..K16, which the generator emits one per cycle, into a 16-entry register file. It then replays them on demand through a valid/ready stream, either forward (encrypt, K1→K16) or reversed (decrypt, K16→K1). This lets one key schedule serve any number of blocks in either direction without re-running the generator.

## Interface
Parameters:
- NROUNDS, 16, number of subkeys stored; fixed by DES, not to be overridden.
- KW, 48, subkey width in bits.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- key_start  in  1  one-cycle pulse, a new key schedule follows; restarts loading.
- kn_valid  in  1  kn carries the next subkey in generation order.
- kn  in  [1:48]  subkey from the generator (bit 1 = MSB, DES numbering).
- kn_done  in  1  generator finished pulse.
- rd_start  in  1  one-cycle pulse, begin a 16-subkey replay.
- rd_decrypt  in  1  sampled with rd_start; 1 = reverse order.
- k_valid  out  1  k_out/k_round valid.
- k_ready  in  1  consumer accepts the current subkey.
- k_out  out  [1:48]  current subkey.
- k_round  out  4  round index 0..15 of the current beat, in consumption order.
- k_last  out  1  high with the 16th beat.
- loaded  out  1  full schedule stored and replayable.
- load_err  out  1  sticky; cleared by key_start or reset.
- par_err  out  1  sticky parity error; present only with the parity option (see Configuration).

## Operation
FSM states: EMPTY, LOADING, LOADED, STREAM. Reset enters EMPTY.

Loading:
- key_start in any state → LOADING next cycle, wr_cnt=0, loaded=0, load_err=0.
- If the block was in STREAM, k_valid drops the next cycle.
- LOADING: each kn_valid beat writes slot[wr_cnt] and increments wr_cnt.
- After the 16th write, go to LOADED; loaded=1 from the following cycle.
- kn_done in LOADING with wr_cnt<16 → load_err=1, go to EMPTY.
- kn_done and kn_valid in the same cycle: the write happens first, and the count check includes that write.
- kn_valid outside LOADING is ignored; slot contents are unchanged.
- kn_done in LOADED, or coinciding with the 16th write, is not an error.

Replay:
- rd_start in LOADED → STREAM.
- rd_start samples rd_decrypt into dir; rd_idx = 0 (encrypt) or 15 (decrypt); beat = 0.
- rd_start in EMPTY, LOADING or STREAM is ignored.
- STREAM: k_valid=1, k_out=slot[rd_idx], k_round=beat, k_last=(beat==15).
- Handshake: a beat completes when k_valid&&k_ready. On completion, rd_idx steps ±1 per dir and beat increments.
- k_ready low holds all outputs stable.
- The handshake on the k_last beat returns to LOADED. Stored keys are retained, so replay is unlimited.
- key_start and rd_start in the same cycle: key_start wins.

Arithmetic:
- wr_cnt is 5 bits and saturates at 16.
- rd_idx and beat are 4 bits and never wrap inside a replay.

## Timing
- Reset values: k_valid=0, k_out=0, k_round=0, k_last=0, loaded=0, load_err=0, par_err=0. Slots are not reset.
- Load: the 16th kn_valid at cycle N → loaded=1 at N+1.
- Replay latency: rd_start at cycle N → first k_valid at N+1.
- With k_ready held high, 16 beats are consecutive (N+1..N+16) and k_valid=0 at N+17.
- Back-to-back replay: rd_start is accepted the cycle after the last handshake.
- k_out, k_round and k_last are registered outputs; no combinational path from k_ready to any output.
- Asynchronous reset mid-stream clears state immediately; loaded=0.

## Configuration
- DES_SUBKEY_PARITY_EN defined: each slot stores an extra even-parity bit computed from kn at write time.
  - Every completed handshake rechecks parity of k_out.
  - On mismatch, par_err sets (sticky) the cycle after that handshake; the stream continues.
  - par_err is cleared by reset only.
- Not defined: no parity storage, par_err tied to 0, storage is exactly 16×48 bits.

## Test plan
- Load 16 beats kn=48'h000000000001<<i (i=0..15), then rd_start with rd_decrypt=0 and k_ready=1 → k_out sequence matches write order, k_round 0..15, k_last only on beat 15, loaded stays 1.
- Same load, rd_start with rd_decrypt=1 → first k_out = 16th written key, last k_out = first written key.
- Stream with k_ready toggled 1,0,0,1,… → k_out held during stalls, exactly 16 accepted beats, no skipped or duplicated keys.
- key_start, 10 kn_valid beats, then kn_done → load_err=1, loaded=0, and a subsequent rd_start produces no k_valid.
- key_start pulsed at beat 5 of a replay → k_valid=0 next cycle, loaded=0. Reload of 16 new keys, then replay → only the new keys appear.
- With DES_SUBKEY_PARITY_EN: force one stored bit of slot 3 after loading, then replay forward → par_err rises the cycle after beat 3 and stays high.
